// File: rtl/ps2_rx_frontend.sv
// PS/2 receive front end: synchronises and filters the raw line pair, deserialises
// 11-bit frames into checked bytes and folds E0/F0 prefixes into a 16-bit keycode.
module ps2_rx_frontend #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PS2Data,
  input  logic        PS2Clk,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [15:0] keycode,
  output logic        keycode_valid,
  output logic        parity_err,
  output logic        frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, fall_q, bit_q;
  logic [FW-1:0] flt_cnt_q;
  logic          fall_d;

  state_t        state_q;
  logic [7:0]    shift_q, pend_q, byte_data_q;
  logic [2:0]    bit_cnt_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;
  logic [15:0]   keycode_q;
  logic          byte_valid_q, keycode_valid_q, parity_err_q, frame_err_q;

  // The filtered clock drops this cycle: FILTER_LEN-th consecutive low sample.
  assign fall_d = filt_q & ~clk_s2_q & (flt_cnt_q == FLT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
      fall_q    <= 1'b0;
      bit_q     <= 1'b1;
    end else begin
      clk_s1_q <= PS2Clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2Data;
      dat_s2_q <= dat_s1_q;
      fall_q   <= fall_d;
      bit_q    <= dat_s2_q;
      if (clk_s2_q != filt_q) begin
        if (flt_cnt_q == FLT_MAX) begin
          filt_q    <= clk_s2_q;
          flt_cnt_q <= '0;
        end else begin
          flt_cnt_q <= flt_cnt_q + FW'(1);
        end
      end else begin
        flt_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      par_q           <= 1'b0;
      pend_q          <= '0;
      to_cnt_q        <= '0;
      byte_data_q     <= '0;
      keycode_q       <= '0;
      byte_valid_q    <= 1'b0;
      keycode_valid_q <= 1'b0;
      parity_err_q    <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      byte_valid_q    <= 1'b0;
      keycode_valid_q <= 1'b0;
      parity_err_q    <= 1'b0;
      frame_err_q     <= 1'b0;

      if (fall_q)
        to_cnt_q <= '0;
      else if (state_q != IDLE && to_cnt_q != TO_MAX)
        to_cnt_q <= to_cnt_q + TW'(1);

      if (fall_q) begin
        case (state_q)
          IDLE: if (!bit_q) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
          DATA: begin
            shift_q   <= {bit_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= bit_q;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!bit_q) begin
              frame_err_q <= 1'b1;
            end else if (!(^shift_q ^ par_q)) begin
              parity_err_q <= 1'b1;
            end else begin
              byte_data_q  <= shift_q;
              byte_valid_q <= 1'b1;
              // Prefixes only arm the next keycode; a later prefix replaces an earlier one.
              if (shift_q == 8'hE0 || shift_q == 8'hF0) begin
                pend_q <= shift_q;
              end else begin
                keycode_q       <= {pend_q, shift_q};
                keycode_valid_q <= 1'b1;
                pend_q          <= '0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE && to_cnt_q == TO_MAX) begin
        // Abandoned frame: drop the partial byte but keep any pending prefix.
        state_q     <= IDLE;
        shift_q     <= '0;
        bit_cnt_q   <= '0;
        frame_err_q <= 1'b1;
      end
    end
  end

  assign byte_data     = byte_data_q;
  assign byte_valid    = byte_valid_q;
  assign keycode       = keycode_q;
  assign keycode_valid = keycode_valid_q;
  assign parity_err    = parity_err_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Directed and randomised PS/2 frames against a byte/keycode reference model.
module tb_ps2_rx_frontend;
  localparam int FLT  = 8;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic        clk = 1'b0, rst_n = 1'b0, PS2Data = 1'b1, PS2Clk = 1'b1;
  logic [7:0]  byte_data;
  logic        byte_valid, keycode_valid, parity_err, frame_err;
  logic [15:0] keycode;

  ps2_rx_frontend #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .PS2Data(PS2Data), .PS2Clk(PS2Clk),
    .byte_data(byte_data), .byte_valid(byte_valid), .keycode(keycode),
    .keycode_valid(keycode_valid), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, fall_cyc = 0;
  int m_bv, m_kv, m_pe, m_fe;
  int m_long = 0, m_lat_bad = 0;
  logic p_bv = 0, p_kv = 0, p_pe = 0, p_fe = 0;

  logic [7:0]  mdl_pend = 8'h00, mdl_bd = 8'h00;
  logic [15:0] mdl_kc = 16'h0000;

  always @(posedge clk) cyc++;

  // Pulse monitor: counts events per frame, flags pulses longer than one cycle.
  always @(negedge clk) begin
    if (byte_valid) begin
      m_bv++;
      if (cyc - fall_cyc < 6 || cyc - fall_cyc > 16) m_lat_bad++;
    end
    if (keycode_valid) m_kv++;
    if (parity_err) m_pe++;
    if (frame_err) m_fe++;
    if ((byte_valid && p_bv) || (keycode_valid && p_kv) || (parity_err && p_pe) || (frame_err && p_fe))
      m_long++;
    p_bv = byte_valid; p_kv = keycode_valid; p_pe = parity_err; p_fe = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    m_bv = 0; m_kv = 0; m_pe = 0; m_fe = 0;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nb);
    for (int i = 0; i < nb; i++) begin
      PS2Data = bits[i];
      tick(HALF);
      PS2Clk = 1'b0;
      fall_cyc = cyc;
      tick(HALF);
      PS2Clk = 1'b1;
    end
    PS2Data = 1'b1;
  endtask

  task automatic expect_counts(input string tag, input int bv, input int kv, input int pe, input int fe);
    chk({tag, " byte_valid count"}, m_bv, bv);
    chk({tag, " keycode_valid count"}, m_kv, kv);
    chk({tag, " parity_err count"}, m_pe, pe);
    chk({tag, " frame_err count"}, m_fe, fe);
    chk({tag, " byte_data"}, {24'h0, byte_data}, {24'h0, mdl_bd});
    chk({tag, " keycode"}, {16'h0, keycode}, {16'h0, mdl_kc});
  endtask

  // Reference: frame fate decided from stop bit, then odd parity, then prefix folding.
  task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
    logic p;
    logic [10:0] bits;
    int e_bv, e_kv, e_pe, e_fe;
    p = (~^b) ^ bad_par;
    bits = {~bad_stop, p, b, 1'b0};
    e_bv = 0; e_kv = 0; e_pe = 0; e_fe = 0;
    if (bad_stop) e_fe = 1;
    else if (bad_par) e_pe = 1;
    else begin
      e_bv = 1;
      mdl_bd = b;
      if (b == 8'hE0 || b == 8'hF0) mdl_pend = b;
      else begin
        e_kv = 1;
        mdl_kc = {mdl_pend, b};
        mdl_pend = 8'h00;
      end
    end
    clr();
    send_bits(bits, 11);
    tick(30);
    expect_counts(tag, e_bv, e_kv, e_pe, e_fe);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, " byte_data"}, {24'h0, byte_data}, 32'h0);
    chk({tag, " keycode"}, {16'h0, keycode}, 32'h0);
    chk({tag, " pulses"}, {28'h0, byte_valid, keycode_valid, parity_err, frame_err}, 32'h0);
  endtask

  task automatic glitch(input int len, input string tag);
    clr();
    PS2Data = 1'b0;
    PS2Clk = 1'b0;
    tick(len);
    PS2Clk = 1'b1;
    tick(10);
    PS2Data = 1'b1;
    tick(20);
    expect_counts(tag, 0, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] rb;
    int r;
    tick(5);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick(20);

    frame(8'h1C, 0, 0, "make 1C");
    frame(8'hF0, 0, 0, "prefix F0");
    frame(8'h1C, 0, 0, "break F01C");
    frame(8'h1C, 0, 0, "pending cleared 1C");
    frame(8'hE0, 0, 0, "prefix E0");
    frame(8'hF0, 0, 0, "prefix F0 after E0");
    frame(8'h75, 0, 0, "ext break F075");
    frame(8'h1C, 1, 0, "bad parity");
    frame(8'h1C, 0, 1, "bad stop");
    frame(8'h1C, 1, 1, "bad stop and parity");

    glitch(3, "glitch 3");
    frame(8'h1C, 0, 0, "after glitch 3");
    glitch(FLT - 1, "glitch 7");
    frame(8'h5A, 0, 0, "after glitch 7");

    // Timeout with a prefix pending: the prefix must survive the aborted frame.
    frame(8'hF0, 0, 0, "prefix before timeout");
    clr();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
    tick(TO + 60);
    expect_counts("timeout", 0, 0, 0, 1);
    frame(8'h1C, 0, 0, "after timeout F01C");

    // Reset mid-frame clears everything, including the pending prefix.
    frame(8'hE0, 0, 0, "prefix before reset");
    clr();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
    rst_n = 1'b0;
    tick(3);
    check_zero_outputs("mid-frame reset");
    mdl_pend = 8'h00; mdl_bd = 8'h00; mdl_kc = 16'h0000;
    rst_n = 1'b1;
    tick(TO + 60);
    expect_counts("after reset release", 0, 0, 0, 0);
    frame(8'h1C, 0, 0, "after reset 001C");

    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 7);
      rb = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      frame(rb, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            $sformatf("random %0d byte %0h", i, rb));
    end

    chk("pulse width", m_long, 0);
    chk("byte_valid latency window", m_lat_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
